// File: rtl/ldpc_pkg.sv
// Shared constants for the LDPC min-sum decoder datapath.
// Message/magnitude widths, check-node degree and offset value.
package ldpc_pkg;

  localparam int MSG_W  = 10;
  localparam int MAG_W  = MSG_W - 1;
  localparam int CN_DEG = 7;
  localparam int OFFSET = 1;

  typedef logic [3:0] cnt_t;

endpackage

// File: rtl/cnu_7_if.sv
// Message bus of the degree-7 check node unit.
// Carries the phase counter, V2C inputs and C2V outputs.
interface cnu_7_if
  import ldpc_pkg::*;
#(
  parameter int W = MSG_W
) ();

  cnt_t         cnt;
  logic [W-1:0] V2C_1, V2C_2, V2C_3, V2C_4;
  logic [W-1:0] V2C_5, V2C_6, V2C_7;
  logic [W-1:0] C2V_1, C2V_2, C2V_3, C2V_4;
  logic [W-1:0] C2V_5, C2V_6, C2V_7;

  modport master (
    output cnt,
    output V2C_1, V2C_2, V2C_3, V2C_4,
    output V2C_5, V2C_6, V2C_7,
    input  C2V_1, C2V_2, C2V_3, C2V_4,
    input  C2V_5, C2V_6, C2V_7
  );

  modport slave (
    input  cnt,
    input  V2C_1, V2C_2, V2C_3, V2C_4,
    input  V2C_5, V2C_6, V2C_7,
    output C2V_1, C2V_2, C2V_3, C2V_4,
    output C2V_5, C2V_6, C2V_7
  );

endinterface

// File: rtl/cnu_min2.sv
// Two-minimum search over seven magnitudes.
// Pairwise compare-merge tree; lower index wins on ties.
module cnu_min2
  import ldpc_pkg::*;
#(
  parameter int MW = MAG_W
) (
  input  logic [MW-1:0] mag [CN_DEG],
  output logic [MW-1:0] min1,
  output logic [MW-1:0] min2,
  output logic [2:0]    idx
);

  localparam int NW = 2 * MW + 3;

  function automatic logic [NW-1:0] leaf(
    input logic [MW-1:0] m,
    input logic [2:0]    i
  );
    return {m, {MW{1'b1}}, i};
  endfunction

  // a always covers lower indices than b
  function automatic logic [NW-1:0] merge(
    input logic [NW-1:0] a,
    input logic [NW-1:0] b
  );
    logic [MW-1:0] a1, a2, b1, b2;
    a1 = a[NW-1 -: MW];
    a2 = a[MW+2 -: MW];
    b1 = b[NW-1 -: MW];
    b2 = b[MW+2 -: MW];
    if (b1 < a1)
      return {b1, (a1 < b2) ? a1 : b2, b[2:0]};
    else
      return {a1, (b1 < a2) ? b1 : a2, a[2:0]};
  endfunction

  logic [NW-1:0] lf [CN_DEG];
  logic [NW-1:0] s1 [3];
  logic [NW-1:0] s2 [2];
  logic [NW-1:0] s3;

  // merge tree: 7 leaves -> 4 -> 2 -> 1
  always_comb begin
    for (int i = 0; i < CN_DEG; i++)
      lf[i] = leaf(mag[i], 3'(i));
    s1[0] = merge(lf[0], lf[1]);
    s1[1] = merge(lf[2], lf[3]);
    s1[2] = merge(lf[4], lf[5]);
    s2[0] = merge(s1[0], s1[1]);
    s2[1] = merge(s1[2], lf[6]);
    s3    = merge(s2[0], s2[1]);
  end

  assign min1 = s3[NW-1 -: MW];
  assign min2 = s3[MW+2 -: MW];
  assign idx  = s3[2:0];

endmodule

// File: rtl/cnu_7.sv
// Degree-7 min-sum check node unit, phased by cnt.
// Define CNU_OFFSET_EN for offset min-sum magnitudes.
module cnu_7
  import ldpc_pkg::*;
#(
  parameter int   W        = MSG_W,
  parameter cnt_t LOAD_CNT = 4'd0
) (
  input logic   clk,
  input logic   rst,
  cnu_7_if.slave bus
);

  localparam int MW = W - 1;

  logic [W-1:0]  v2c   [CN_DEG];
  logic [W-1:0]  cap_q [CN_DEG];
  logic [W-1:0]  c2v_q [CN_DEG];
  logic [W-1:0]  c2v_d [CN_DEG];
  logic [MW-1:0] mag   [CN_DEG];
  logic [CN_DEG-1:0] sgn;
  logic          par;
  logic          ph_q;
  logic [MW-1:0] min1, min2;
  logic [2:0]    idx;

  assign v2c[0] = bus.V2C_1;
  assign v2c[1] = bus.V2C_2;
  assign v2c[2] = bus.V2C_3;
  assign v2c[3] = bus.V2C_4;
  assign v2c[4] = bus.V2C_5;
  assign v2c[5] = bus.V2C_6;
  assign v2c[6] = bus.V2C_7;

  assign bus.C2V_1 = c2v_q[0];
  assign bus.C2V_2 = c2v_q[1];
  assign bus.C2V_3 = c2v_q[2];
  assign bus.C2V_4 = c2v_q[3];
  assign bus.C2V_5 = c2v_q[4];
  assign bus.C2V_6 = c2v_q[5];
  assign bus.C2V_7 = c2v_q[6];

  // sign/magnitude split; most negative saturates
  always_comb begin
    logic [W-1:0] neg;
    for (int i = 0; i < CN_DEG; i++) begin
      sgn[i] = cap_q[i][W-1];
      neg    = -cap_q[i];
      if (cap_q[i] == {1'b1, {MW{1'b0}}})
        mag[i] = '1;
      else if (sgn[i])
        mag[i] = neg[MW-1:0];
      else
        mag[i] = cap_q[i][MW-1:0];
    end
    par = ^sgn;
  end

  cnu_min2 #(.MW(MW)) u_min2 (
    .mag  (mag),
    .min1 (min1),
    .min2 (min2),
    .idx  (idx)
  );

  // extrinsic magnitude and sign per output
  always_comb begin
    logic [MW-1:0] om;
    for (int i = 0; i < CN_DEG; i++) begin
      om = (idx == 3'(i)) ? min2 : min1;
`ifdef CNU_OFFSET_EN
      om = (om == '0) ? '0 : om - MW'(OFFSET);
`endif
      c2v_d[i] = (par ^ sgn[i]) ? -{1'b0, om}
                                :  {1'b0, om};
    end
  end

  // capture on LOAD_CNT, update outputs one edge later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph_q <= 1'b0;
      for (int i = 0; i < CN_DEG; i++) begin
        cap_q[i] <= '0;
        c2v_q[i] <= '0;
      end
    end else begin
      ph_q <= (bus.cnt == LOAD_CNT);
      for (int i = 0; i < CN_DEG; i++) begin
        if (bus.cnt == LOAD_CNT) cap_q[i] <= v2c[i];
        if (ph_q) c2v_q[i] <= c2v_d[i];
      end
    end
  end

endmodule

// File: tb/tb_cnu_7.sv
// Randomized bench for cnu_7 against a leave-one-out
// min-sum reference model; honours CNU_OFFSET_EN.
module tb_cnu_7;
  import ldpc_pkg::*;

  localparam int   W    = MSG_W;
  localparam cnt_t LOAD = 4'd0;
  localparam int   NEGMAX = -(1 << (W - 1));

  logic clk = 1'b0;
  logic rst = 1'b1;
  cnt_t cnt;

  cnu_7_if #(.W(W)) bus ();

  cnu_7 #(.W(W), .LOAD_CNT(LOAD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int vin  [CN_DEG];
  int cap  [CN_DEG];
  int expv [CN_DEG];
  bit flag;

  task automatic chk(input string tag,
                     input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d",
               tag, $signed(got), $signed(exp));
    end
  endtask

  function automatic logic [W-1:0] c2v(input int i);
    case (i)
      0: return bus.C2V_1;
      1: return bus.C2V_2;
      2: return bus.C2V_3;
      3: return bus.C2V_4;
      4: return bus.C2V_5;
      5: return bus.C2V_6;
      default: return bus.C2V_7;
    endcase
  endfunction

  function automatic int mag_of(input int v);
    if (v == NEGMAX) return -NEGMAX - 1;
    return (v < 0) ? -v : v;
  endfunction

  // output i: sign product and min magnitude of the other six
  function automatic int ref_c2v(input int i);
    int mn;
    bit neg;
    mn  = 1 << 30;
    neg = 0;
    for (int j = 0; j < CN_DEG; j++) begin
      if (j == i) continue;
      if (cap[j] < 0) neg = ~neg;
      if (mag_of(cap[j]) < mn) mn = mag_of(cap[j]);
    end
`ifdef CNU_OFFSET_EN
    mn = (mn > OFFSET) ? mn - OFFSET : 0;
`endif
    return neg ? -mn : mn;
  endfunction

  task automatic apply();
    bus.cnt   = cnt;
    bus.V2C_1 = W'(vin[0]);
    bus.V2C_2 = W'(vin[1]);
    bus.V2C_3 = W'(vin[2]);
    bus.V2C_4 = W'(vin[3]);
    bus.V2C_5 = W'(vin[4]);
    bus.V2C_6 = W'(vin[5]);
    bus.V2C_7 = W'(vin[6]);
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < CN_DEG; i++)
      chk($sformatf("%s_c2v%0d", tag, i + 1), c2v(i), W'(expv[i]));
  endtask

  task automatic check_const(input string tag, input int e [CN_DEG]);
    for (int i = 0; i < CN_DEG; i++)
      chk($sformatf("%s_c2v%0d", tag, i + 1), c2v(i), W'(e[i]));
  endtask

  task automatic model_reset();
    flag = 0;
    for (int i = 0; i < CN_DEG; i++) begin
      cap[i]  = 0;
      expv[i] = 0;
    end
  endtask

  // one clock edge: update the model, advance cnt, check outputs
  task automatic tick(output bit comp);
    cnt_t c;
    bit   r;
    c    = cnt;
    r    = rst;
    comp = 0;
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      if (flag) begin
        for (int i = 0; i < CN_DEG; i++) expv[i] = ref_c2v(i);
        comp = 1;
      end
      flag = 0;
      if (c == LOAD) begin
        for (int i = 0; i < CN_DEG; i++) cap[i] = vin[i];
        flag = 1;
      end
    end
    #1;
    cnt = cnt + 4'd1;
    apply();
    check_all("cyc");
  endtask

  task automatic run_to_compute();
    bit comp;
    for (int k = 0; k < 40; k++) begin
      tick(comp);
      if (comp) return;
    end
    checks++;
    errors++;
    $display("FAIL compute_timeout got=none exp=update");
  endtask

  task automatic run_until_cnt(input cnt_t v);
    bit comp;
    for (int k = 0; k < 20 && cnt != v; k++) tick(comp);
  endtask

  function automatic int rnd_v();
    case ($urandom_range(0, 5))
      0: return NEGMAX;
      1: return 0;
      2: return int'($urandom_range(0, 6)) - 3;
      default: return int'($urandom_range(0, (1 << W) - 1)) + NEGMAX;
    endcase
  endfunction

  int e_ref [CN_DEG];
  int e_tie [CN_DEG];
  int e_sat [CN_DEG];
  int e_zer [CN_DEG];

  initial begin
    bit comp;
`ifdef CNU_OFFSET_EN
    e_ref = '{-7, 7, -8, 7, -7, 7, -7};
    e_tie = '{-4, 4, -4, -4, -4, -4, -4};
    e_sat = '{99, -99, -99, -99, -99, -99, -99};
    e_zer = '{0, 0, -99, 0, 0, 0, 0};
`else
    e_ref = '{-8, 8, -9, 8, -8, 8, -8};
    e_tie = '{-5, 5, -5, -5, -5, -5, -5};
    e_sat = '{100, -100, -100, -100, -100, -100, -100};
    e_zer = '{0, 0, -100, 0, 0, 0, 0};
`endif
    cnt = 4'd0;
    for (int i = 0; i < CN_DEG; i++) vin[i] = 0;
    apply();
    model_reset();

    #2;
    check_all("reset");
    tick(comp);
    tick(comp);
    rst = 1'b0;

    vin = '{-17, 16, -8, 9, -10, 12, -11};
    apply();
    run_to_compute();
    check_const("ref", e_ref);

    vin = '{5, -5, 20, 30, 40, 50, 60};
    apply();
    run_to_compute();
    check_const("tie", e_tie);

    vin = '{NEGMAX, 100, 100, 100, 100, 100, 100};
    apply();
    run_to_compute();
    check_const("sat", e_sat);

    vin[2] = 0;
    apply();
    run_to_compute();
    check_const("zero", e_zer);

    run_until_cnt(4'd5);
    for (int i = 0; i < CN_DEG; i++) vin[i] = rnd_v();
    apply();
    run_until_cnt(4'd0);
    check_const("hold", e_zer);
    tick(comp);
    check_const("hold_cap", e_zer);
    tick(comp);

    run_until_cnt(4'd1);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("rst_async");
    for (int k = 0; k < 3; k++) tick(comp);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) tick(comp);

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < CN_DEG; i++) vin[i] = rnd_v();
      apply();
      for (int k = 0; k < int'($urandom_range(1, 20)); k++)
        tick(comp);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
